midi_voice_allocator: RTL
=========================

MIDI_VOICE_ALLOCATOR -- requirements
Module: midi_voice_allocator

Interface
REQ-001 Parameter NUM_VOICES, default 4, number of voice slots driven (2..8).
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 rx_data  input  8  MIDI byte from UART receiver.
REQ-005 rx_valid  input  1  one-cycle strobe qualifying rx_data; may assert every cycle.
REQ-006 channel  input  4  MIDI channel to respond to (0..15).
REQ-007 voice_note  output  8*NUM_VOICES  note per voice; voice i at [8i+7:8i]; feeds voice midi_data.
REQ-008 voice_velocity  output  8*NUM_VOICES  velocity per voice, same packing.
REQ-009 voice_gate  output  NUM_VOICES  gate per voice; feeds voice enable.
REQ-010 msg_error  output  1  one-cycle pulse on a data byte received with no running status.

Function
REQ-011 Bytes are processed only when rx_valid=1; otherwise the state holds.
REQ-012 Parser states: IDLE (no running status), WAIT_D1, WAIT_D2, SKIP (SysEx/system common).
REQ-013 Status 0x80-0xEF: store as running status; go to WAIT_D1; expected data count is 1 for 0xC_/0xD_, 2 otherwise.
REQ-014 Status 0xF8-0xFF (real-time): ignored; state, running status and partial data unchanged.
REQ-015 Status 0xF0-0xF7: clear running status; go to SKIP; data bytes in SKIP are ignored without msg_error.
REQ-016 Data byte in IDLE: pulse msg_error for one cycle; state unchanged.
REQ-017 On completion of a message's final data byte: go to WAIT_D1 and keep the running status.
REQ-018 Only messages whose status low nibble equals channel act; all others are parsed and discarded.
REQ-019 Note-on (0x9n) with velocity>0: if a gated voice already holds the note, update its velocity only; gate stays 1.
REQ-020 Otherwise, allocate to the lowest-index voice with gate=0 and load note/velocity; gate=1.
REQ-021 If no voice is free: steal voice steal_ptr; steal_ptr increments modulo NUM_VOICES.
REQ-022 Stolen voice: gate=0 for exactly one cycle with the new note/velocity loaded, then gate=1 (ADSR retrigger).
REQ-023 Note-off (0x8n), or note-on with velocity 0: gate=0 on every gated voice holding that note; note/velocity retained for release.
REQ-024 Control change 0xBn with D1=0x7B (all notes off): all gates=0 on completion; note/velocity retained.
REQ-025 Other messages (poly/channel pressure, program change, pitch bend, other CC) have no output effect.
REQ-026 Latency: outputs update on the edge that samples the final data byte; they are visible the following cycle.
REQ-027 A new status byte received mid-message abandons the partial message; the new status is processed normally.
REQ-028 Data bytes are 7-bit; bit 7=0 is guaranteed by byte classification; stored values have bit 7=0.
REQ-029 An event arriving while a steal retrigger is pending applies on top of it; a note-off for the stolen note cancels the pending gate=1.

Reset
REQ-030 rst=1: voice_note=0, voice_velocity=0, voice_gate=0, msg_error=0, state IDLE, running status cleared, steal_ptr=0.
REQ-031 rst has priority over rx_valid in the same cycle; reset mid-message discards the partial message.

Verification
REQ-032 channel=0; bytes 0x90,0x3C,0x64 -> voice 0 note=0x3C, velocity=0x64, gate=1 one cycle after the third byte; other gates=0.
REQ-033 Running status: 0x90,0x3C,0x64,0x40,0x50 -> voice 1 note=0x40 gated; then 0x3C,0x00 -> voice 0 gate=0, note stays 0x3C.
REQ-034 NUM_VOICES=4; five distinct note-ons -> fifth note goes to voice 0: gate 0 for one cycle, then 1 with the new note; steal_ptr=1.
REQ-035 0x90,0x3C,0xF8,0x64 -> the real-time byte is ignored and the note-on completes normally; 0x3C with no prior status -> msg_error pulses.
REQ-036 channel=0; 0x91,0x3C,0x64 -> no output change; 0xB0,0x7B,0x00 with 3 voices gated -> all gates=0.
REQ-037 rst asserted after 0x90,0x3C; then 0x64 -> msg_error pulses, all outputs remain 0.

Source files
------------

// File: rtl/midi_voice_allocator.sv
// MIDI byte-stream parser with polyphonic voice allocation: note-on/off and
// all-notes-off drive per-voice note, velocity and gate, with round-robin stealing.
module midi_voice_allocator #(
  parameter int NUM_VOICES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  input  logic [3:0]              channel,
  output logic [8*NUM_VOICES-1:0] voice_note,
  output logic [8*NUM_VOICES-1:0] voice_velocity,
  output logic [NUM_VOICES-1:0]   voice_gate,
  output logic                    msg_error,
  output logic [1:0]              parser_state,
  output logic [2:0]              steal_ptr
);

  // Input handshake: rx_valid is a one-cycle strobe with no back-pressure; every
  // cycle with rx_valid=1 delivers exactly one byte, which is always consumed.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_D1 = 2'd1,
    WAIT_D2 = 2'd2,
    SKIP    = 2'd3
  } state_t;

  state_t                state;
  logic [7:0]            run_status;
  logic [6:0]            d1_q;
  logic [6:0]            note_q [NUM_VOICES];
  logic [6:0]            vel_q  [NUM_VOICES];
  logic [NUM_VOICES-1:0] gate_q;
  logic [NUM_VOICES-1:0] retrig_q;

  logic       is_data, is_realtime, is_system, is_channel, one_data_msg;
  logic       complete, ch_match, ev_on, ev_off, ev_all_off;
  logic [3:0] msg_type;
  logic [6:0] d2;

  assign is_data      = ~rx_data[7];
  assign is_realtime  = rx_data >= 8'hF8;
  assign is_system    = (rx_data[7:4] == 4'hF) && !is_realtime;
  assign is_channel   = rx_data[7] && (rx_data[7:4] != 4'hF);
  assign msg_type     = run_status[7:4];
  assign one_data_msg = (msg_type == 4'hC) || (msg_type == 4'hD);
  assign d2           = rx_data[6:0];

  // Single-data messages (program change, channel pressure) have no output effect,
  // so only two-data completions can raise an event.
  assign complete   = rx_valid && is_data && (state == WAIT_D2);
  assign ch_match   = run_status[3:0] == channel;
  assign ev_on      = complete && ch_match && (msg_type == 4'h9) && (d2 != 7'd0);
  assign ev_off     = complete && ch_match &&
                      ((msg_type == 4'h8) || ((msg_type == 4'h9) && (d2 == 7'd0)));
  assign ev_all_off = complete && ch_match && (msg_type == 4'hB) && (d1_q == 7'h7B);

  logic [NUM_VOICES-1:0] g_eff, n_gate, n_retrig;
  logic [6:0]            n_note [NUM_VOICES];
  logic [6:0]            n_vel  [NUM_VOICES];
  logic [2:0]            n_ptr, hit_idx, free_idx;
  logic                  hit_found, free_found;

  // A pending retrigger counts as gated, so events in the following cycle apply
  // on top of it and a note-off can cancel it.
  always_comb begin
    g_eff      = gate_q | retrig_q;
    n_gate     = g_eff;
    n_retrig   = '0;
    n_ptr      = steal_ptr;
    hit_found  = 1'b0;
    free_found = 1'b0;
    hit_idx    = 3'd0;
    free_idx   = 3'd0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      n_note[i] = note_q[i];
      n_vel[i]  = vel_q[i];
    end
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (!hit_found && g_eff[i] && (note_q[i] == d1_q)) begin
        hit_found = 1'b1;
        hit_idx   = 3'(i);
      end
      if (!free_found && !g_eff[i]) begin
        free_found = 1'b1;
        free_idx   = 3'(i);
      end
    end
    if (ev_on) begin
      if (hit_found) begin
        for (int i = 0; i < NUM_VOICES; i++)
          if (3'(i) == hit_idx) n_vel[i] = d2;
      end else if (free_found) begin
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (3'(i) == free_idx) begin
            n_note[i] = d1_q;
            n_vel[i]  = d2;
            n_gate[i] = 1'b1;
          end
        end
      end else begin
        // Steal: drop the gate for one cycle so the envelope retriggers.
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (3'(i) == steal_ptr) begin
            n_note[i]   = d1_q;
            n_vel[i]    = d2;
            n_gate[i]   = 1'b0;
            n_retrig[i] = 1'b1;
          end
        end
        n_ptr = (steal_ptr == 3'(NUM_VOICES - 1)) ? 3'd0 : steal_ptr + 3'd1;
      end
    end else if (ev_off) begin
      for (int i = 0; i < NUM_VOICES; i++)
        if (g_eff[i] && (note_q[i] == d1_q)) n_gate[i] = 1'b0;
    end else if (ev_all_off) begin
      n_gate = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      run_status <= 8'h00;
      d1_q       <= 7'd0;
      msg_error  <= 1'b0;
      steal_ptr  <= 3'd0;
      gate_q     <= '0;
      retrig_q   <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_q[i] <= 7'd0;
        vel_q[i]  <= 7'd0;
      end
    end else begin
      msg_error <= rx_valid && is_data && (state == IDLE);
      gate_q    <= n_gate;
      retrig_q  <= n_retrig;
      steal_ptr <= n_ptr;
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_q[i] <= n_note[i];
        vel_q[i]  <= n_vel[i];
      end
      if (rx_valid) begin
        if (is_channel) begin
          run_status <= rx_data;
          state      <= WAIT_D1;
        end else if (is_system) begin
          run_status <= 8'h00;
          state      <= SKIP;
        end else if (is_data) begin
          case (state)
            WAIT_D1: begin
              d1_q  <= d2;
              state <= one_data_msg ? WAIT_D1 : WAIT_D2;
            end
            WAIT_D2: state <= WAIT_D1;
            default: state <= state;
          endcase
        end
      end
    end
  end

  assign parser_state = state;
  assign voice_gate   = gate_q;

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
    assign voice_note[8*g +: 8]     = {1'b0, note_q[g]};
    assign voice_velocity[8*g +: 8] = {1'b0, vel_q[g]};
  end

endmodule
